uart_tx_param: RTL and testbench

Parametrised UART transmitter: the next generation of the team's fixed 8N1 transmitter. Serialises bytes at a compile-time bit period with configurable data width, parity and stop bits. An optional input FIFO gives back-to-back frames with no idle gap. Sits between the USB/command logic and the FPGA UART TX pin; the upstream source pushes bytes with a ready/valid handshake.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_tx_fifo.sv | 65 ++++++
 rtl/uart_tx_param.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmitter and the future receiver.
//   PARITY_NONE/ODD/EVEN  - parity mode codes (0/1/2)
//   S_IDLE..S_STOP        - frame state encodings
//   tx_state_e            - enum built on those encodings
//   calc_parity()         - parity bit for a data word (zero-extended to 8 bits)
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP   = S_STOP
    } tx_state_e;

    // Zero padding above the real data width does not change the XOR.
    function automatic logic calc_parity(input logic [7:0] data, input int mode);
        logic x;
        x = ^data;
        if (mode == PARITY_EVEN)
            return x;
        else if (mode == PARITY_ODD)
            return ~x;
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: generic synchronous FIFO with combinational read port.
//   clk, rst          - clock, synchronous active-high reset (flushes contents)
//   push, push_data   - write request; ignored while full
//   pop, pop_data     - read request; pop_data shows the head entry
//   full, empty       - status from registered count
//   count             - number of stored entries (0..DEPTH)
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    // Gated on the registered full flag: a push into a full FIFO is lost
    // even when a pop frees a slot on the same edge.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (start, DATA_BITS LSB first,
// optional parity, STOP_BITS stop bits), CLKS_PER_BIT clocks per bit.
// Optional input FIFO enabled by defining UART_TX_FIFO_EN.
//   i_Clock      - clock
//   i_Reset      - synchronous active-high reset; aborts any frame, flushes FIFO
//   i_Tx_DV      - byte valid; accepted when o_Tx_Ready is high
//   i_Tx_Byte    - byte to send
//   o_Tx_Ready   - can accept a byte this cycle
//   o_Tx_Active  - a frame is on the line
//   o_Tx_Serial  - registered serial line (idle high)
//   o_Tx_Done    - one-cycle pulse on the edge ending the last stop bit
//   o_Fifo_Count - queued bytes (excludes the byte being shifted out)
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks
            $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
            $error("uart_tx_param: DATA_BITS must be 5..8");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
    endgenerate

    tx_state_e              state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [IDX_W-1:0]       idx, idx_n;
    logic [DATA_BITS-1:0]   shift, shift_n;
    logic                   par, par_n;
    logic                   serial, serial_n;
    logic                   done, done_n;
    logic                   bit_end;
    logic                   load;
    logic                   byte_avail;
    logic [DATA_BITS-1:0]   next_byte;

`ifdef UART_TX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_Clock),
        .rst       (i_Reset),
        .push      (i_Tx_DV),
        .push_data (i_Tx_Byte),
        .pop       (load),
        .pop_data  (next_byte),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (o_Fifo_Count)
    );

    assign o_Tx_Ready = !fifo_full;
    assign byte_avail = !fifo_empty;
`else
    // Single-byte path: the byte goes straight into the shift register on
    // the accept edge, so ready only while idle.
    assign o_Tx_Ready   = (state == ST_IDLE);
    assign byte_avail   = i_Tx_DV && o_Tx_Ready;
    assign next_byte    = i_Tx_Byte;
    assign o_Fifo_Count = '0;
`endif

    assign bit_end     = (cnt == CNT_LAST);
    assign o_Tx_Active = (state != ST_IDLE);
    assign o_Tx_Serial = serial;
    assign o_Tx_Done   = done;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        shift_n  = shift;
        par_n    = par;
        serial_n = serial;
        done_n   = 1'b0;
        load     = 1'b0;

        if (state != ST_IDLE)
            cnt_n = bit_end ? '0 : cnt + CNT_W'(1);

        case (state)
            ST_IDLE: begin
                if (byte_avail) begin
                    load    = 1'b1;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_n = ST_DATA;
                    idx_n   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx == DATA_LAST) begin
                        idx_n   = '0;
                        state_n = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_n   = idx + IDX_W'(1);
                        shift_n = shift >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_n = ST_STOP;
                    idx_n   = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (idx == STOP_LAST) begin
                        done_n = 1'b1;
                        // Chain straight into the next start bit: no idle gap.
                        if (byte_avail) begin
                            load    = 1'b1;
                            state_n = ST_START;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (load) begin
            shift_n = next_byte;
            par_n   = calc_parity(8'(next_byte), PARITY);
            cnt_n   = '0;
            idx_n   = '0;
        end

        // Line level is registered from the next state so it changes on the
        // same edge as the state.
        case (state_n)
            ST_IDLE:   serial_n = 1'b1;
            ST_START:  serial_n = 1'b0;
            ST_DATA:   serial_n = shift_n[0];
            ST_PARITY: serial_n = par_n;
            ST_STOP:   serial_n = 1'b1;
            default:   serial_n = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            idx    <= '0;
            shift  <= '0;
            par    <= 1'b0;
            serial <= 1'b1;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            shift  <= shift_n;
            par    <= par_n;
            serial <= serial_n;
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: self-checking bench for uart_tx_param at CLKS_PER_BIT=4.
// u0: 8N1 (scoreboarded line monitor), u1: 8E1, u2: 8O1, u3: 7E2.
// Works with or without UART_TX_FIFO_EN defined.
module tb_uart_tx_param;

`ifdef UART_TX_FIFO_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dv  = '0;
    logic [7:0] byt [4];
    logic [3:0] rdy, act, ser, done;
    logic [2:0] fcnt0, fcnt1, fcnt2, fcnt3;

    always #5 clk = ~clk;

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[0]), .i_Tx_Byte(byt[0]),
        .o_Tx_Ready(rdy[0]), .o_Tx_Active(act[0]), .o_Tx_Serial(ser[0]),
        .o_Tx_Done(done[0]), .o_Fifo_Count(fcnt0));
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[1]), .i_Tx_Byte(byt[1]),
        .o_Tx_Ready(rdy[1]), .o_Tx_Active(act[1]), .o_Tx_Serial(ser[1]),
        .o_Tx_Done(done[1]), .o_Fifo_Count(fcnt1));
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[2]), .i_Tx_Byte(byt[2]),
        .o_Tx_Ready(rdy[2]), .o_Tx_Active(act[2]), .o_Tx_Serial(ser[2]),
        .o_Tx_Done(done[2]), .o_Fifo_Count(fcnt2));
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[3]), .i_Tx_Byte(byt[3][6:0]),
        .o_Tx_Ready(rdy[3]), .o_Tx_Active(act[3]), .o_Tx_Serial(ser[3]),
        .o_Tx_Done(done[3]), .o_Fifo_Count(fcnt3));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- u0 line monitor + scoreboard ----------------
    logic [7:0] sb [$];
    int         done_cyc [$];
    int         frames = 0;
    int         mon_t0 = -1;
    bit         mon_act_ok = 1'b1;
    logic [9:0] mon_line = '0;
    logic [9:0] last_line = '0;

    always @(posedge clk) begin : mon
        int off;
        logic [7:0] exp_b;
        #1;
        if (rst) begin
            mon_t0 = -1;
        end else begin
            if (mon_t0 < 0 && ser[0] === 1'b0) begin
                mon_t0 = cyc;
                mon_act_ok = 1'b1;
            end
            if (done[0] === 1'b1) done_cyc.push_back(cyc);
            if (mon_t0 >= 0) begin
                off = cyc - mon_t0;
                if (off < 40) begin
                    if (act[0] !== 1'b1) mon_act_ok = 1'b0;
                    if (off % 4 == 2) mon_line[off/4] = ser[0];
                    if (done[0] !== 1'b0) begin
                        n_vec++; n_err++;
                        $display("FAIL early_done: done at offset %0d required at 40", off);
                    end
                end else begin
                    frames++;
                    last_line = mon_line;
                    check("done_at_40", {31'b0, done[0]}, 32'd1);
                    check("active_40", {31'b0, mon_act_ok}, 32'd1);
                    check("stop_bit", {31'b0, mon_line[9]}, 32'd1);
                    if (sb.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL sb_data: frame %0h sent, none expected", mon_line[8:1]);
                    end else begin
                        exp_b = sb.pop_front();
                        check("sb_data", {24'b0, mon_line[8:1]}, {24'b0, exp_b});
                    end
                    mon_act_ok = 1'b1;
                    mon_t0 = (ser[0] === 1'b0) ? cyc : -1;
                end
            end else if (done[0] === 1'b1) begin
                n_vec++; n_err++;
                $display("FAIL stray_done: done=1 required 0 outside a frame");
            end
        end
    end

    task automatic send0(input logic [7:0] b);
        dv[0]  = 1'b1;
        byt[0] = b;
        if (rdy[0] === 1'b1) sb.push_back(b);
        @(posedge clk); #1;
        dv[0] = 1'b0;
    endtask

    task automatic wait_frames(input int target, input string tag);
        int n = 0;
        while (frames < target && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (frames < target) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout: frames %0d required %0d", tag, frames, target);
        end
    endtask

    // One frame on DUT d; parity sampled mid-bit at bit position par_idx.
    task automatic parity_frame(input int d, input logic [7:0] b, input int par_idx,
                                input logic exp_par, input int pulse_at, input string tag);
        int   s = -1;
        int   dn = -1;
        int   ndone = 0;
        int   rdy_low = 0;
        logic par = 1'bx;
        dv[d]  = 1'b1;
        byt[d] = b;
        @(posedge clk); #1;
        dv[d] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (s < 0 && ser[d] === 1'b0) s = i;
            if (done[d] === 1'b1) begin
                ndone++;
                if (dn < 0) dn = i;
            end
            if (rdy[d] !== 1'b1) rdy_low++;
            if (s >= 0 && i == s + par_idx*4 + 2) par = ser[d];
            if (i == pulse_at) begin
                dv[d]  = 1'b1;
                byt[d] = 8'h7F;
            end else begin
                dv[d] = 1'b0;
            end
            @(posedge clk); #1;
        end
        check({tag, "_latency"}, s, LAT);
        check({tag, "_length"}, dn - s, 44);
        check({tag, "_parity"}, {31'b0, par}, {31'b0, exp_par});
        check({tag, "_one_done"}, ndone, 1);
        check({tag, "_ready_idle"}, {31'b0, rdy[d]}, 32'd1);
        if (pulse_at >= 0) check({tag, "_ready_low"}, rdy_low, 44);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // bit 0 = start bit, bit 9 = stop bit
    } vec_t;
    vec_t tbl [5];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f0, n0;
        bit line_ok, no_done;
        tbl[0] = '{8'h55, 10'h2AA};
        tbl[1] = '{8'hA3, 10'h346};
        tbl[2] = '{8'h00, 10'h200};
        tbl[3] = '{8'hFF, 10'h3FE};
        tbl[4] = '{8'h81, 10'h302};
        for (int i = 0; i < 4; i++) byt[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_serial", {31'b0, ser[0]}, 32'd1);
        check("rst_active", {31'b0, act[0]}, 32'd0);
        check("rst_done", {31'b0, done[0]}, 32'd0);
        check("rst_ready", {31'b0, rdy[0]}, 32'd1);
        check("rst_count", {29'b0, fcnt0}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // single frames, 8N1
        for (int i = 0; i < 5; i++) begin
            f0 = frames;
            send0(tbl[i].data);
            wait_frames(f0 + 1, "table");
            check($sformatf("line_%0h", tbl[i].data), {22'b0, last_line}, {22'b0, tbl[i].line});
        end

        // three pushes on consecutive edges
        f0 = frames;
        n0 = done_cyc.size();
        send0(8'h11); send0(8'h22); send0(8'h33);
`ifdef UART_TX_FIFO_EN
        wait_frames(f0 + 3, "b2b");
        check("b2b_gap1", done_cyc[n0+1] - done_cyc[n0], 40);
        check("b2b_gap2", done_cyc[n0+2] - done_cyc[n0+1], 40);
`else
        wait_frames(f0 + 1, "b2b");
        repeat (60) @(posedge clk);
        #1;
        check("nofifo_one_frame", frames - f0, 1);
`endif

        // six pushes into a depth-4 FIFO
`ifdef UART_TX_FIFO_EN
        repeat (5) @(posedge clk);
        #1;
        f0 = frames;
        for (int i = 0; i < 6; i++) send0(8'hC0 + 8'(i));
        check("full_count", {29'b0, fcnt0}, 32'd4);
        check("full_ready", {31'b0, rdy[0]}, 32'd0);
        wait_frames(f0 + 5, "fill");
        repeat (60) @(posedge clk);
        #1;
        check("fill_frames", frames - f0, 5);
        check("fill_sb_empty", sb.size(), 0);
`endif

        // reset in the middle of the data bits
        repeat (5) @(posedge clk);
        #1;
        send0(8'h3C); send0(8'h4D); send0(8'h5E);
        repeat (10) @(posedge clk);
        #1;
`ifdef UART_TX_FIFO_EN
        check("pre_rst_count", {29'b0, fcnt0}, 32'd2);
`endif
        check("pre_rst_active", {31'b0, act[0]}, 32'd1);
        f0 = frames;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_serial", {31'b0, ser[0]}, 32'd1);
        check("mid_rst_count", {29'b0, fcnt0}, 32'd0);
        check("mid_rst_active", {31'b0, act[0]}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        line_ok = 1'b1;
        no_done = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (ser[0] !== 1'b1) line_ok = 1'b0;
            if (done[0] !== 1'b0) no_done = 1'b0;
            @(posedge clk); #1;
        end
        check("post_rst_idle", {31'b0, line_ok}, 32'd1);
        check("post_rst_no_done", {31'b0, no_done}, 32'd1);
        check("post_rst_frames", frames - f0, 0);

        // parity variants
        parity_frame(1, 8'h07, 9, 1'b1, -1, "8E1");
        parity_frame(2, 8'h07, 9, 1'b0, -1, "8O1");
`ifdef UART_TX_FIFO_EN
        parity_frame(3, 8'h07, 8, 1'b1, -1, "7E2");
`else
        parity_frame(3, 8'h07, 8, 1'b1, 20, "7E2");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
